fpga_soc_reset_sequencer: RTL and testbench

//  Board-level controller between the FPGA clock wizard and cgra_x_heep_top.

---
 rtl/fpga_soc_reset_sequencer.sv | 172 +++++++++++++++++
 tb/tb_fpga_soc_reset_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_soc_reset_sequencer.sv
// Board-level SoC reset sequencer: lock wait, button debounce, reset hold, strap capture, exit LEDs.
// Optional watchdog enabled by defining FPGA_RST_WDT_EN.
module fpga_soc_reset_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned HOLD_CYCLES     = 64,
  parameter int unsigned WDT_CYCLES      = 2**26
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       locked_i,
  input  logic       btn_i,
  input  logic       boot_select_i,
  input  logic       execute_from_flash_i,
  input  logic       exit_valid_i,
  input  logic       exit_value_i,
  input  logic       heartbeat_i,
  output logic       soc_rst_no,
  output logic       boot_select_o,
  output logic       execute_from_flash_o,
  output logic       run_led_o,
  output logic       exit_valid_led_o,
  output logic       exit_value_led_o,
  output logic [2:0] state_o,
  output logic [7:0] reset_count_o
);

  localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HoldW = $clog2(HOLD_CYCLES);

  typedef enum logic [2:0] {
    StWaitLock = 3'd0,
    StHold     = 3'd1,
    StRun      = 3'd2,
    StExited   = 3'd3
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       lock_sync_q, btn_sync_q, boot_sync_q, xff_sync_q;
  logic [1:0]       warm_q;
  logic             btn_db_q, armed_q, btn_press_q;
  logic [DbW-1:0]   db_cnt_q;
  logic [HoldW-1:0] hold_cnt_q;
  logic             exit_valid_q;
  logic             soc_rst_n_q, boot_q, xff_q, exit_value_q;
  logic [7:0]       reset_count_q;
  logic             lock_s, exit_rise, hold_last, enter_hold, hold_done, wdt_expire;

  assign lock_s    = lock_sync_q[1];
  assign exit_rise = exit_valid_i & ~exit_valid_q;
  assign hold_last = (state_q == StHold) && (hold_cnt_q == HoldW'(HOLD_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWaitLock: if (lock_s) state_d = StHold;
      StHold: begin
        if (!lock_s)          state_d = StWaitLock;
        else if (btn_press_q) state_d = StHold;
        else if (hold_last)   state_d = StRun;
      end
      StRun: begin
        if (!lock_s)          state_d = StWaitLock;
        else if (btn_press_q) state_d = StHold;
        else if (wdt_expire)  state_d = StHold;
        else if (exit_rise)   state_d = StExited;
      end
      StExited: begin
        if (!lock_s)          state_d = StWaitLock;
        else if (btn_press_q) state_d = StHold;
      end
      default: state_d = StWaitLock;
    endcase
  end

  assign enter_hold = (state_d == StHold) && ((state_q != StHold) || btn_press_q);
  assign hold_done  = (state_q == StHold) && (state_d == StRun);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StWaitLock;
      lock_sync_q   <= '0;
      btn_sync_q    <= '0;
      boot_sync_q   <= '0;
      xff_sync_q    <= '0;
      warm_q        <= '0;
      btn_db_q      <= 1'b0;
      armed_q       <= 1'b0;
      btn_press_q   <= 1'b0;
      db_cnt_q      <= '0;
      hold_cnt_q    <= '0;
      exit_valid_q  <= 1'b0;
      soc_rst_n_q   <= 1'b0;
      boot_q        <= 1'b0;
      xff_q         <= 1'b0;
      exit_value_q  <= 1'b0;
      reset_count_q <= '0;
    end else begin
      state_q      <= state_d;
      lock_sync_q  <= {lock_sync_q[0], locked_i};
      btn_sync_q   <= {btn_sync_q[0], btn_i};
      boot_sync_q  <= {boot_sync_q[0], boot_select_i};
      xff_sync_q   <= {xff_sync_q[0], execute_from_flash_i};
      warm_q       <= {warm_q[0], 1'b1};
      exit_valid_q <= exit_valid_i;
      soc_rst_n_q  <= (state_d == StRun) || (state_d == StExited);

      btn_press_q <= 1'b0;
      if (btn_sync_q[1] != btn_db_q) begin
        if (db_cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
          btn_db_q    <= btn_sync_q[1];
          db_cnt_q    <= '0;
          btn_press_q <= btn_sync_q[1] & armed_q;
        end else begin
          db_cnt_q <= db_cnt_q + DbW'(1);
        end
      end else begin
        db_cnt_q <= '0;
      end
      // Presses only count once the button has been seen released after reset.
      if (warm_q[1] && !btn_db_q && !btn_sync_q[1]) armed_q <= 1'b1;

      if (enter_hold)             hold_cnt_q <= '0;
      else if (state_q == StHold) hold_cnt_q <= hold_cnt_q + HoldW'(1);
      else                        hold_cnt_q <= '0;

      if (hold_done) begin
        boot_q <= boot_sync_q[1];
        xff_q  <= xff_sync_q[1];
        if (reset_count_q != 8'hFF) reset_count_q <= reset_count_q + 8'd1;
      end

      if ((state_d == StHold) || (state_d == StWaitLock)) exit_value_q <= 1'b0;
      else if ((state_q == StRun) && (state_d == StExited)) exit_value_q <= exit_value_i;
    end
  end

`ifdef FPGA_RST_WDT_EN
  localparam int unsigned WdtW = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;

  logic [2:0]      hb_sync_q;
  logic [WdtW-1:0] wdt_cnt_q;
  logic            hb_edge;

  assign hb_edge    = hb_sync_q[2] ^ hb_sync_q[1];
  assign wdt_expire = (state_q == StRun) && (wdt_cnt_q == WdtW'(WDT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hb_sync_q <= '0;
      wdt_cnt_q <= '0;
    end else begin
      hb_sync_q <= {hb_sync_q[1:0], heartbeat_i};
      if ((state_q != StRun) || hb_edge) wdt_cnt_q <= '0;
      else                               wdt_cnt_q <= wdt_cnt_q + WdtW'(1);
    end
  end
`else
  logic unused_wdt;
  assign wdt_expire = 1'b0;
  assign unused_wdt = heartbeat_i ^ (WDT_CYCLES == 0);
`endif

  assign soc_rst_no           = soc_rst_n_q;
  assign boot_select_o        = boot_q;
  assign execute_from_flash_o = xff_q;
  assign run_led_o            = (state_q == StRun) || (state_q == StExited);
  assign exit_valid_led_o     = (state_q == StExited);
  assign exit_value_led_o     = exit_value_q;
  assign state_o              = state_q;
  assign reset_count_o        = reset_count_q;

endmodule

// File: tb/tb_fpga_soc_reset_sequencer.sv
// Randomized scoreboard bench for fpga_soc_reset_sequencer; WDT section builds with FPGA_RST_WDT_EN.
module tb_fpga_soc_reset_sequencer;
  localparam int unsigned DB = 4, HOLD = 8, WDT = 32;

  logic clk = 1'b0;
  logic rst_i = 1'b1, locked_i = 1'b0, btn_i = 1'b0, boot_select_i = 1'b0;
  logic execute_from_flash_i = 1'b0, exit_valid_i = 1'b0, exit_value_i = 1'b0;
  logic heartbeat_i = 1'b0;
  logic soc_rst_no, boot_select_o, execute_from_flash_o, run_led_o;
  logic exit_valid_led_o, exit_value_led_o;
  logic [2:0] state_o;
  logic [7:0] reset_count_o;

  always #5 clk = ~clk;

  fpga_soc_reset_sequencer #(
    .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES    (HOLD),
    .WDT_CYCLES     (WDT)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst_i),
    .locked_i            (locked_i),
    .btn_i               (btn_i),
    .boot_select_i       (boot_select_i),
    .execute_from_flash_i(execute_from_flash_i),
    .exit_valid_i        (exit_valid_i),
    .exit_value_i        (exit_value_i),
    .heartbeat_i         (heartbeat_i),
    .soc_rst_no          (soc_rst_no),
    .boot_select_o       (boot_select_o),
    .execute_from_flash_o(execute_from_flash_o),
    .run_led_o           (run_led_o),
    .exit_valid_led_o    (exit_valid_led_o),
    .exit_value_led_o    (exit_value_led_o),
    .state_o             (state_o),
    .reset_count_o       (reset_count_o)
  );

  typedef struct {
    int unsigned count;
    logic        boot;
    logic        xff;
  } rst_exp_t;

  rst_exp_t rst_q[$];
  logic     exit_q[$];
  int checks = 0, errors = 0;

  // Reference model: what the board should look like between operations.
  int unsigned m_count = 0;
  logic m_boot = 1'b0, m_xff = 1'b0, m_exited = 1'b0, m_val = 1'b0;
  logic hb_en = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pick_straps();
    boot_select_i        = 1'($urandom);
    execute_from_flash_i = 1'($urandom);
  endtask

  // A completed HOLD bumps the saturating counter and captures the current straps.
  task automatic expect_reset();
    rst_exp_t e;
    m_count  = (m_count < 255) ? m_count + 1 : 255;
    m_boot   = boot_select_i;
    m_xff    = execute_from_flash_i;
    m_exited = 1'b0;
    m_val    = 1'b0;
    e.count  = m_count;
    e.boot   = m_boot;
    e.xff    = m_xff;
    rst_q.push_back(e);
  endtask

  task automatic check_run(input string tag);
    check({tag, "_state"}, 32'(state_o), m_exited ? 32'd3 : 32'd2);
    check({tag, "_soc_rst_no"}, 32'(soc_rst_no), 32'd1);
    check({tag, "_run_led"}, 32'(run_led_o), 32'd1);
    check({tag, "_exit_valid_led"}, 32'(exit_valid_led_o), 32'(m_exited));
    check({tag, "_exit_value_led"}, 32'(exit_value_led_o), 32'(m_val));
    check({tag, "_boot_select"}, 32'(boot_select_o), 32'(m_boot));
    check({tag, "_xff"}, 32'(execute_from_flash_o), 32'(m_xff));
    check({tag, "_reset_count"}, 32'(reset_count_o), m_count);
  endtask

  task automatic do_press(input int hi);
    pick_straps();
    cyc(4);
    expect_reset();
    btn_i = 1'b1;
    cyc(hi);
    btn_i = 1'b0;
    cyc(30);
    check_run("press");
  endtask

  task automatic do_bounce(input int len);
    btn_i = 1'b1;
    cyc(len);
    btn_i = 1'b0;
    cyc(12);
    check_run("bounce");
  endtask

  task automatic do_toggle();
    for (int i = 0; i < 10; i++) begin
      pick_straps();
      cyc(1);
    end
    cyc(3);
    check_run("toggle");
  endtask

  task automatic do_exit(input logic v);
    exit_value_i = v;
    if (!m_exited) begin
      exit_q.push_back(v);
      m_exited = 1'b1;
      m_val    = v;
    end
    exit_valid_i = 1'b1;
    cyc(1);
    exit_value_i = ~v;
    cyc(3);
    exit_valid_i = 1'b0;
    cyc(2);
    check_run("exit");
  endtask

  task automatic do_lockloss(input logic with_btn);
    locked_i = 1'b0;
    btn_i    = with_btn;
    cyc(4);
    check("lockloss_state", 32'(state_o), 32'd0);
    check("lockloss_soc_rst_no", 32'(soc_rst_no), 32'd0);
    check("lockloss_exit_leds", 32'({exit_valid_led_o, exit_value_led_o}), 32'd0);
    cyc(10);
    btn_i = 1'b0;
    cyc(20);
    pick_straps();
    cyc(3);
    expect_reset();
    locked_i = 1'b1;
    cyc(20);
    check_run("relock");
  endtask

  task automatic do_rst();
    rst_i = 1'b1;
    pick_straps();
    cyc(1);
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_soc_rst_no", 32'(soc_rst_no), 32'd0);
    check("rst_count", 32'(reset_count_o), 32'd0);
    check("rst_outputs", 32'({boot_select_o, execute_from_flash_o, run_led_o,
                              exit_valid_led_o, exit_value_led_o}), 32'd0);
    m_count = 0;
    expect_reset();
    rst_i = 1'b0;
    cyc(25);
    check_run("rst_rerun");
  endtask

  // Scoreboard monitor: pops expectations when the DUT releases reset or raises the exit LED.
  initial begin : monitor
    int       hold_len = 0;
    logic     prev_soc = 1'b0, prev_evl = 1'b0, ev;
    rst_exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_i && soc_rst_no && !prev_soc) begin
        if (rst_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_reset: soc_rst_no rose with count %0d, required no reset",
                   reset_count_o);
        end else begin
          e = rst_q.pop_front();
          check("mon_hold_len", 32'(hold_len), HOLD);
          check("mon_reset_count", 32'(reset_count_o), e.count);
          check("mon_boot_select", 32'(boot_select_o), 32'(e.boot));
          check("mon_xff", 32'(execute_from_flash_o), 32'(e.xff));
        end
      end
      if (!rst_i && exit_valid_led_o && !prev_evl) begin
        if (exit_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_exit: exit_valid_led rose, required no exit");
        end else begin
          ev = exit_q.pop_front();
          check("mon_exit_value", 32'(exit_value_led_o), 32'(ev));
        end
      end
      hold_len = (state_o == 3'd1) ? hold_len + 1 : 0;
      prev_soc = soc_rst_no;
      prev_evl = exit_valid_led_o;
    end
  end

  initial begin : heartbeat_gen
    forever begin
      cyc(20);
      if (hb_en) heartbeat_i = ~heartbeat_i;
    end
  end

  initial begin : time_limit
    #2000000;
    $display("FAIL time_limit: bench still running, required completion");
    $fatal(1);
  end

  initial begin : stimulus
    int op;
    cyc(2);
    check("reset_soc_rst_no", 32'(soc_rst_no), 32'd0);
    check("reset_state", 32'(state_o), 32'd0);
    check("reset_outputs", 32'({boot_select_o, execute_from_flash_o, run_led_o,
                                exit_valid_led_o, exit_value_led_o, reset_count_o}), 32'd0);
    boot_select_i        = 1'b1;
    execute_from_flash_i = 1'b0;
    expect_reset();
    rst_i    = 1'b0;
    locked_i = 1'b1;
    cyc(25);
    check_run("first_run");

    do_toggle();
    do_bounce(1);
    do_bounce(2);
    do_bounce(3);
    do_press(10);
    do_exit(1'b1);
    do_exit(1'b0);
    do_press(12);
    do_lockloss(1'b1);

`ifdef FPGA_RST_WDT_EN
    begin : wdt_test
      bit seen = 0;
      hb_en = 1'b0;
      pick_straps();
      expect_reset();
      for (int i = 0; i < 80 && !seen; i++) begin
        cyc(1);
        if (state_o == 3'd1) seen = 1;
      end
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL wdt_timeout: no HOLD within 80 cycles, required watchdog reset");
      end
      hb_en = 1'b1;
      cyc(20);
      check_run("wdt_rerun");
      cyc(500);
      check_run("wdt_fed");
    end
`endif

    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 9);
      case (op)
        0, 1:    do_press($urandom_range(10, 20));
        2:       do_bounce($urandom_range(1, 3));
        3, 4:    do_exit(1'($urandom));
        5, 6:    do_toggle();
        7, 8:    do_lockloss(1'($urandom));
        default: do_rst();
      endcase
    end

    cyc(20);
    check("pending_resets", 32'(rst_q.size()), 32'd0);
    check("pending_exits", 32'(exit_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
